// File: rtl/spi_tx.sv
// SPI mode-0 serializer, MSB first: data changes while data_clk_out is low, the receiver samples on its rising edge.
// Define SPI_TX_BURST_EN to let a trigger on the done_out cycle chain the next word without releasing sel_out.
module spi_tx #(
  parameter int DATA_WIDTH      = 8,
  parameter int DATA_CLK_PERIOD = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  trigger_in,
  output logic                  data_out,
  output logic                  data_clk_out,
  output logic                  sel_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int HALF    = DATA_CLK_PERIOD / 2;
  localparam int PHASE_W = $clog2(DATA_CLK_PERIOD);
  localparam int IDX_W   = $clog2(DATA_WIDTH);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DATA_CLK_PERIOD - 1);
  localparam logic [PHASE_W-1:0] PHASE_HIGH = PHASE_W'(HALF);
  localparam logic [PHASE_W-1:0] GAP_LAST   = PHASE_W'(HALF - 1);
  localparam logic [IDX_W-1:0]   IDX_MSB    = IDX_W'(DATA_WIDTH - 1);

`ifdef SPI_TX_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  state_e                 state_q;
  logic [PHASE_W-1:0]     phase_q;
  logic [IDX_W-1:0]       bit_idx_q;
  logic [DATA_WIDTH-1:0]  shreg_q;
  logic                   data_q;
  logic                   sclk_q;
  logic                   sel_q;
  logic                   busy_q;
  logic                   done_q;

  logic [PHASE_W-1:0]     phase_d;
  logic                   last_cycle;
  logic                   load_word;

  assign phase_d    = phase_q + PHASE_W'(1);
  assign last_cycle = (state_q == SHIFT) && (phase_q == PHASE_LAST) && (bit_idx_q == '0);

  // A word is accepted from IDLE, or back-to-back on the final cycle of the previous word in burst builds.
  assign load_word  = trigger_in && ((state_q == IDLE) || (BURST_EN && last_cycle));

  always_ff @(posedge clk_in) begin
    // NOTE: reset is synchronous here, so it only acts on a clock edge and takes priority over everything else.
    if (rst_in) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sel_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
      done_q <= 1'b0;
      if (load_word) begin
        state_q   <= SHIFT;
        phase_q   <= '0;
        bit_idx_q <= IDX_MSB;
        shreg_q   <= data_in;
        data_q    <= data_in[DATA_WIDTH-1];
        sclk_q    <= 1'b0;
        sel_q     <= 1'b0;
        busy_q    <= 1'b1;
      end else begin
        case (state_q)
          IDLE: ;
          SHIFT: begin
            if (phase_q != PHASE_LAST) begin
              phase_q <= phase_d;
              sclk_q  <= (phase_d >= PHASE_HIGH);
              done_q  <= (phase_d == PHASE_LAST) && (bit_idx_q == '0);
            end else if (bit_idx_q != '0) begin
              // Bit boundary: the clock falls and the next lower bit appears in the same cycle.
              phase_q   <= '0;
              bit_idx_q <= bit_idx_q - IDX_W'(1);
              shreg_q   <= shreg_q << 1;
              data_q    <= shreg_q[DATA_WIDTH-2];
              sclk_q    <= 1'b0;
            end else begin
              state_q <= GAP;
              phase_q <= '0;
              data_q  <= 1'b0;
              sclk_q  <= 1'b0;
              sel_q   <= 1'b1;
            end
          end
          GAP: begin
            if (phase_q == GAP_LAST) begin
              state_q <= IDLE;
              phase_q <= '0;
              busy_q  <= 1'b0;
            end else begin
              phase_q <= phase_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_out     = data_q;
  assign data_clk_out = sclk_q;
  assign sel_out      = sel_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;

endmodule

// File: tb/tb_spi_tx.sv
// Bench for spi_tx: a cycle-indexed transfer model checked every cycle, plus directed literal checks.
// Honours SPI_TX_BURST_EN the same way the design does.
module tb_spi_tx;

  localparam int W    = 8;
  localparam int P    = 4;
  localparam int HALF = P / 2;
  localparam int WP   = W * P;

  logic         clk = 1'b0;
  logic         rst_in = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         trigger_in = 1'b0;
  logic         data_out, data_clk_out, sel_out, busy_out, done_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

`ifdef SPI_TX_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  spi_tx #(.DATA_WIDTH(W), .DATA_CLK_PERIOD(P)) dut (
    .clk_in       (clk),
    .rst_in       (rst_in),
    .data_in      (data_in),
    .trigger_in   (trigger_in),
    .data_out     (data_out),
    .data_clk_out (data_clk_out),
    .sel_out      (sel_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a transfer is just "accepted at cycle t0 with word w"; outputs follow from k = cyc - t0 - 1.
  bit       m_valid = 1'b0;
  bit       m_active = 1'b0;
  int       m_t0 = 0;
  logic [W-1:0] m_word = '0;
  logic     prev_clk = 1'b0;
  logic     rx_bits[$];

  always @(negedge clk) begin
    int   k;
    logic e_sel, e_clk, e_data, e_busy, e_done;
    k = cyc - m_t0 - 1;
    if (m_active && k >= WP + HALF) m_active = 1'b0;
    e_sel = 1'b1; e_clk = 1'b0; e_data = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (m_active && k < WP) begin
      e_sel  = 1'b0;
      e_clk  = (k % P) >= HALF;
      e_data = m_word[W - 1 - k / P];
      e_busy = 1'b1;
      e_done = (k == WP - 1);
    end else if (m_active) begin
      e_busy = 1'b1;
    end
    if (m_valid) begin
      check("sel_out", sel_out, e_sel);
      check("data_clk_out", data_clk_out, e_clk);
      check("data_out", data_out, e_data);
      check("busy_out", busy_out, e_busy);
      check("done_out", done_out, e_done);
      if (!sel_out && data_clk_out && !prev_clk) rx_bits.push_back(data_out);
    end
    prev_clk = data_clk_out;
    if (rst_in) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
    end else if (m_valid && trigger_in) begin
      if (!m_active || (BURST && k == WP - 1)) begin
        m_active = 1'b1;
        m_t0     = cyc;
        m_word   = data_in;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string name, input logic [W-1:0] exp);
    logic [W-1:0] w;
    w = '0;
    check({name, " bits available"}, 32'(rx_bits.size() >= W), 32'd1);
    if (rx_bits.size() >= W) begin
      for (int i = 0; i < W; i++) w = {w[W-2:0], rx_bits.pop_front()};
      check(name, w, exp);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w);
    data_in    = w;
    trigger_in = 1'b1;
    tick(1);
    trigger_in = 1'b0;
    tick(40);
  endtask

  initial begin
    int sel_low, dones, rises;
    logic last_clk;

    // Reset held for three cycles
    tick(3);
    check("reset sel_out", sel_out, 1);
    check("reset data_clk_out", data_clk_out, 0);
    check("reset data_out", data_out, 0);
    check("reset busy_out", busy_out, 0);
    check("reset done_out", done_out, 0);
    rst_in = 1'b0;
    tick(2);

    // Single word 0xA5 with hand-computed timing landmarks
    data_in = 8'hA5; trigger_in = 1'b1;
    tick(1);                            // T+1
    trigger_in = 1'b0;
    check("A5 sel low at T+1", sel_out, 0);
    check("A5 busy at T+1", busy_out, 1);
    tick(31);                           // T+32
    check("A5 done at T+32", done_out, 1);
    tick(1);                            // T+33
    check("A5 sel high at T+33", sel_out, 1);
    check("A5 done cleared at T+33", done_out, 0);
    tick(1);                            // T+34
    check("A5 busy at T+34", busy_out, 1);
    tick(1);                            // T+35
    check("A5 busy clear at T+35", busy_out, 0);
    tick(5);
    expect_word("A5 word", 8'hA5);

    // Trigger during a transfer is dropped
    data_in = 8'hC3; trigger_in = 1'b1;
    tick(1);
    trigger_in = 1'b0;
    tick(9);                            // T+10
    data_in = 8'h11; trigger_in = 1'b1;
    tick(1);
    trigger_in = 1'b0; data_in = '0;
    tick(40);
    expect_word("C3 word", 8'hC3);
    check("no word after C3", 32'(rx_bits.size()), 0);

    // Trigger held high; data_in changed after acceptance
    data_in = 8'h00; trigger_in = 1'b1;
    tick(1);
    data_in = 8'hFF;
    tick(35);                           // T+36
    trigger_in = 1'b0;
    tick(45);
    expect_word("held first 00", 8'h00);
    expect_word("held second FF", 8'hFF);
    check("held exactly two words", 32'(rx_bits.size()), 0);

    send_word(8'h3C);
    expect_word("3C word", 8'h3C);

    // Abort mid-word
    data_in = 8'h5A; trigger_in = 1'b1;
    tick(1);
    trigger_in = 1'b0;
    tick(11);                           // T+12
    rst_in = 1'b1;
    tick(1);                            // T+13
    rst_in = 1'b0;
    check("abort sel_out", sel_out, 1);
    check("abort data_clk_out", data_clk_out, 0);
    check("abort busy_out", busy_out, 0);
    check("abort done_out", done_out, 0);
    tick(3);
    rx_bits.delete();
    send_word(8'h5A);
    expect_word("5A after abort", 8'h5A);

    // Second trigger coincident with done_out: chained only in burst builds
    sel_low = 0; dones = 0; rises = 0; last_clk = data_clk_out;
    data_in = 8'h12; trigger_in = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      tick(1);
      if (c == 1) trigger_in = 1'b0;
      if (c == 32) begin data_in = 8'h34; trigger_in = 1'b1; end
      if (c == 33) trigger_in = 1'b0;
      if (!sel_out) sel_low++;
      if (done_out) dones++;
      if (data_clk_out && !last_clk) rises++;
      last_clk = data_clk_out;
    end
    check("burst sel low cycles", sel_low, BURST ? 64 : 32);
    check("burst done pulses", dones, BURST ? 2 : 1);
    check("burst rising edges", rises, BURST ? 16 : 8);
    expect_word("burst first 12", 8'h12);
    if (BURST) expect_word("burst second 34", 8'h34);
    check("burst leftover bits", 32'(rx_bits.size()), 0);

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
